// File: rtl/mem_dados_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each access runs IDLE -> ACCESS -> DONE; byte addresses become word addresses.
module mem_dados_arbiter #(
    parameter int unsigned BITS        = 64,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned D_ADDR_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic [D_ADDR_BITS-1:0] p0_addr,
    input  logic [BITS-1:0]        p0_wdata,
    output logic                   p0_ack,
    output logic                   p0_err,
    output logic [BITS-1:0]        p0_rdata,
    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [D_ADDR_BITS-1:0] p1_addr,
    input  logic [BITS-1:0]        p1_wdata,
    output logic                   p1_ack,
    output logic                   p1_err,
    output logic [BITS-1:0]        p1_rdata,
    output logic [D_ADDR_BITS-4:0] mem_addr,
    output logic                   mem_we,
    output logic [BITS-1:0]        mem_din,
    input  logic [BITS-1:0]        mem_dout,
    output logic                   busy
);
    localparam int unsigned WA    = D_ADDR_BITS - 3;
    localparam int unsigned WORDS = 1 << WA;

    // One bit per reachable word address: set when the word exists in memory.
    function automatic logic [WORDS-1:0] word_valid_mask();
        logic [WORDS-1:0] m;
        for (int unsigned i = 0; i < WORDS; i++) begin
            m[i] = (i < DEPTH);
        end
        return m;
    endfunction

    localparam logic [WORDS-1:0] WORD_VALID = word_valid_mask();

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                 state;
    logic                   sel_q;
    logic                   we_q;
    logic                   err_q;
    logic                   last_grant;
    logic                   grant_c;
    logic [D_ADDR_BITS-1:0] addr_c;
    logic [WA-1:0]          waddr_c;
    logic                   bad_c;

    // Sole requester wins; on a tie the port that did not win last time goes.
    always_comb begin
        grant_c = p1_req;
        if (p0_req && p1_req) begin
            grant_c = !last_grant;
        end
        addr_c  = grant_c ? p1_addr : p0_addr;
        waddr_c = addr_c[D_ADDR_BITS-1:3];
        bad_c   = (addr_c[2:0] != 3'd0) || !WORD_VALID[waddr_c];
    end

    // Write strobe follows the state register so reset kills it immediately.
    assign mem_we = (state == ACCESS) && we_q && !err_q;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            last_grant <= 1'b1;
            mem_addr   <= '0;
            mem_din    <= '0;
            p0_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p0_rdata   <= '0;
            p1_ack     <= 1'b0;
            p1_err     <= 1'b0;
            p1_rdata   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        sel_q      <= grant_c;
                        we_q       <= grant_c ? p1_we : p0_we;
                        mem_addr   <= waddr_c;
                        mem_din    <= grant_c ? p1_wdata : p0_wdata;
                        err_q      <= bad_c;
                        last_grant <= grant_c;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Completion status lands on this edge so ack is high during DONE.
                    if (sel_q) begin
                        p1_ack <= 1'b1;
                        p1_err <= err_q;
                        if (!we_q) begin
                            p1_rdata <= err_q ? '0 : mem_dout;
                        end
                    end else begin
                        p0_ack <= 1'b1;
                        p0_err <= err_q;
                        if (!we_q) begin
                            p0_rdata <= err_q ? '0 : mem_dout;
                        end
                    end
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dados_arbiter.sv
// Scoreboard bench for mem_dados_arbiter: driver pushes expected completions,
// a negedge monitor pops and compares them when an ack appears.
module tb_mem_dados_arbiter;
    localparam int unsigned BITS  = 64;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            p0_req, p0_we, p0_ack, p0_err;
    logic [AW-1:0]   p0_addr;
    logic [BITS-1:0] p0_wdata, p0_rdata;
    logic            p1_req, p1_we, p1_ack, p1_err;
    logic [AW-1:0]   p1_addr;
    logic [BITS-1:0] p1_wdata, p1_rdata;
    logic [AW-4:0]   mem_addr;
    logic            mem_we;
    logic [BITS-1:0] mem_din, mem_dout;
    logic            busy;

    mem_dados_arbiter #(.BITS(BITS), .DEPTH(DEPTH), .D_ADDR_BITS(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [BITS-1:0] mem [DEPTH];
    assign mem_dout = mem[32'(mem_addr)];
    always @(posedge clk) if (mem_we) mem[32'(mem_addr)] <= mem_din;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit              port;
        bit              err;
        bit              is_read;
        logic [BITS-1:0] rdata;
    } exp_t;

    exp_t            sbq[$];
    logic [BITS-1:0] exp_rd[2];
    int              checks = 0;
    int              errors = 0;
    int              we_cycles = 0;

    task automatic check(input string name, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: pop one expected completion per ack and compare both ports' status.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) we_cycles++;
            if (mem_we && !busy) check("we_outside_access", 64'(mem_we), 64'd0);
            if (p0_ack && p1_ack) check("dual_ack", 64'(p1_ack), 64'd0);
            if (p0_ack || p1_ack) begin
                if (sbq.size() == 0) begin
                    check("spurious_ack", 64'(p0_ack || p1_ack), 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ack_port", 64'(p1_ack), 64'(e.port));
                    check("ack_err", 64'(e.port ? p1_err : p0_err), 64'(e.err));
                    if (e.is_read) exp_rd[e.port] = e.rdata;
                    check("p0_rdata", p0_rdata, exp_rd[0]);
                    check("p1_rdata", p1_rdata, exp_rd[1]);
                end
            end
        end
    end

    task automatic drive(input bit port, input bit we, input logic [AW-1:0] addr, input logic [BITS-1:0] wd);
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1;
        end
    endtask

    task automatic expect_done(input bit port, input bit err, input bit is_read, input logic [BITS-1:0] rd);
        exp_t e;
        e.port = port; e.err = err; e.is_read = is_read; e.rdata = rd;
        sbq.push_back(e);
    endtask

    // Drop each port's req on its ack; bounded wait.
    task automatic wait_acks(input bit w0, input bit w1, output int c0, output int c1);
        bit d0, d1;
        d0 = !w0; d1 = !w1; c0 = -1; c1 = -1;
        for (int k = 0; k < 30 && !(d0 && d1); k++) begin
            @(negedge clk);
            if (!d0 && p0_ack) begin d0 = 1'b1; c0 = cyc; p0_req = 1'b0; end
            if (!d1 && p1_ack) begin d1 = 1'b1; c1 = cyc; p1_req = 1'b0; end
        end
        check("ack_timeout", 64'(d0 && d1), 64'd1);
    endtask

    task automatic single(input bit port, input bit we, input logic [AW-1:0] addr,
                          input logic [BITS-1:0] wd, input bit err, input logic [BITS-1:0] rd,
                          output int c_ack);
        int start, c0, c1;
        @(negedge clk);
        expect_done(port, err, !we, rd);
        drive(port, we, addr, wd);
        start = cyc;
        wait_acks(!port, port, c0, c1);
        c_ack = port ? c1 : c0;
        check("latency", 64'(c_ack - start), 64'd2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; p0_req = 1'b0; p1_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;
        sbq.delete();
    endtask

    initial begin
        int ca, cb, prev;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 64'h1000 + 64'(i);
        mem[6] = 64'd51;
        rst_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_acks", 64'({p0_ack, p1_ack, p0_err, p1_err, mem_we}), 64'd0);
        check("rst_rdata", p0_rdata | p1_rdata, 64'd0);
        check("rst_mem_bus", 64'(mem_addr) | mem_din, 64'd0);
        rst_n = 1'b1;

        // Reset in the middle of a write must abort it before it commits.
        @(negedge clk);
        drive(1'b0, 1'b1, 6'h10, 64'hAAAA_5555_AAAA_5555);
        @(posedge clk);
        @(negedge clk);
        check("abort_pre_we", 64'(mem_we), 64'd1);
        check("abort_pre_addr", 64'(mem_addr), 64'd2);
        rst_n = 1'b0;
        p0_req = 1'b0;
        #1;
        check("abort_we", 64'(mem_we), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_acks", 64'({p0_ack, p1_ack}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort_word2", mem[2], 64'h1002);
        rst_n = 1'b1;
        exp_rd[0] = '0; exp_rd[1] = '0;

        // Port 0 write then read back.
        single(1'b0, 1'b1, 6'h18, 64'hDEAD_BEEF, 1'b0, '0, ca);
        check("word3", mem[3], 64'hDEAD_BEEF);
        single(1'b0, 1'b0, 6'h18, '0, 1'b0, 64'hDEAD_BEEF, ca);

        // Simultaneous requests after reset: p0 first, then p1.
        do_reset();
        @(negedge clk);
        expect_done(1'b0, 1'b0, 1'b1, 64'h1001);
        expect_done(1'b1, 1'b0, 1'b1, 64'h1004);
        drive(1'b0, 1'b0, 6'h08, '0);
        drive(1'b1, 1'b0, 6'h20, '0);
        wait_acks(1'b1, 1'b1, ca, cb);
        check("rr_gap_p0_p1", 64'(cb - ca), 64'd3);
        // After p0 alone wins, a tie goes to p1 first.
        single(1'b0, 1'b0, 6'h00, '0, 1'b0, 64'h1000, ca);
        @(negedge clk);
        expect_done(1'b1, 1'b0, 1'b1, 64'h1005);
        expect_done(1'b0, 1'b0, 1'b1, 64'h1007);
        drive(1'b0, 1'b0, 6'h38, '0);
        drive(1'b1, 1'b0, 6'h28, '0);
        wait_acks(1'b1, 1'b1, ca, cb);
        check("rr_gap_p1_p0", 64'(ca - cb), 64'd3);

        // Misaligned write is rejected without touching memory.
        prev = we_cycles;
        single(1'b1, 1'b1, 6'h0C, 64'h5555, 1'b1, '0, ca);
        check("misaligned_no_we", 64'(we_cycles - prev), 64'd0);
        check("misaligned_word1", mem[1], 64'h1001);
        // Misaligned read returns zero data.
        single(1'b0, 1'b0, 6'h05, '0, 1'b1, 64'd0, ca);

        // Port 1 reads preloaded word 6.
        single(1'b1, 1'b0, 6'h30, '0, 1'b0, 64'd51, ca);

        // Back-to-back port 0 reads: one completion every 3 cycles.
        single(1'b0, 1'b0, 6'h00, '0, 1'b0, 64'h1000, prev);
        single(1'b0, 1'b0, 6'h08, '0, 1'b0, 64'h1001, ca);
        check("b2b_gap1", 64'(ca - prev), 64'd3);
        single(1'b0, 1'b0, 6'h10, '0, 1'b0, 64'h1002, cb);
        check("b2b_gap2", 64'(cb - ca), 64'd3);

        repeat (6) @(negedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
